// File: rtl/axis_sram_pkg.sv
// Shared opcodes, default response bytes and FSM state encoding for the
// AXI-Stream to SRAM bridge.
package axis_sram_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_READ    = 8'h02;
  localparam logic [7:0] RSP_ACK_DEF = 8'hA5;
  localparam logic [7:0] RSP_ERR_DEF = 8'hEE;

  localparam logic [2:0] ST_HDR   = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/axis_sram_bridge_sram_byte.sv
// Single-port byte SRAM: synchronous write, registered 1-cycle read.
// Contents are deliberately not reset so it maps onto block RAM.
module sram_byte #(
  parameter int ABITS = 11
) (
  input  logic             aclk,
  input  logic             en,
  input  logic             we,
  input  logic [ABITS-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [0:(1<<ABITS)-1];

  // write-or-read port; rdata holds its value when not reading
  always_ff @(posedge aclk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/axis_sram_bridge.sv
// USB-style command bridge: 4-byte header (CMD, ADDR_LO, ADDR_HI, LEN)
// followed by write payload, or a streamed read response.
module axis_sram_bridge
  import axis_sram_pkg::*;
#(
  parameter int         ABITS   = 11,
  parameter logic [7:0] RSP_ACK = RSP_ACK_DEF,
  parameter logic [7:0] RSP_ERR = RSP_ERR_DEF
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       s_axis_tvalid_i,
  output logic       s_axis_tready_o,
  input  logic       s_axis_tlast_i,
  input  logic [7:0] s_axis_tdata_i,
  output logic       m_axis_tvalid_o,
  input  logic       m_axis_tready_i,
  output logic       m_axis_tlast_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       busy_o,
  output logic       err_o
);

  logic [2:0]       state, state_n;
  logic [1:0]       hdr_cnt;
  logic [7:0]       cmd_q, addr_lo_q, len_q, code_q, code_n;
  logic [ABITS-1:0] addr_q;
  logic [8:0]       rd_left;
  logic             rst_done, err_q, err_n;
  logic             resp_ld;
  logic [7:0]       resp_code;

  // read pipeline: sram data in flight, skid, output register
  logic             rd_pend, rd_last;
  logic             skid_vld, skid_last;
  logic [7:0]       skid_data;
  logic             out_vld, out_last;
  logic [7:0]       out_data;

  logic             s_hs, pop, rd_issue, sram_en, sram_we;
  logic [2:0]       occ;
  logic [7:0]       rdata;

  assign s_axis_tready_o = rst_done &&
                           (state == ST_HDR || state == ST_WRITE || state == ST_DRAIN);
  assign s_hs            = s_axis_tvalid_i && s_axis_tready_o;
  assign pop             = out_vld && m_axis_tready_i;

  // Only issue a read if its data is guaranteed a slot (output or skid)
  // even when the consumer stalls next cycle.
  assign occ      = {2'b0, out_vld} + {2'b0, skid_vld} + {2'b0, rd_pend} - {2'b0, pop};
  assign rd_issue = (state == ST_READ) && (rd_left != 9'd0) && (occ <= 3'd1);
  assign sram_we  = (state == ST_WRITE) && s_hs;
  assign sram_en  = sram_we || rd_issue;

  assign m_axis_tvalid_o = out_vld;
  assign m_axis_tlast_o  = out_last;
  assign m_axis_tdata_o  = out_data;
  assign busy_o          = (state != ST_HDR);
  assign err_o           = err_q;

  sram_byte #(.ABITS(ABITS)) u_sram (
    .aclk  (aclk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (addr_q),
    .wdata (s_axis_tdata_i),
    .rdata (rdata)
  );

  // next-state, response loading and error pulse decisions
  always_comb begin
    state_n   = state;
    code_n    = code_q;
    resp_ld   = 1'b0;
    resp_code = RSP_ERR;
    err_n     = 1'b0;
    case (state)
      ST_HDR: begin
        // tlast on a write header leaves no room for payload: discard
        if (s_hs && hdr_cnt == 2'd3 && !(s_axis_tlast_i && cmd_q == CMD_WRITE)) begin
          if (cmd_q == CMD_WRITE)     state_n = ST_WRITE;
          else if (cmd_q == CMD_READ) state_n = ST_READ;
          else begin
            err_n  = 1'b1;
            code_n = RSP_ERR;
            if (s_axis_tlast_i) begin
              state_n = ST_RESP;
              resp_ld = 1'b1;
            end else begin
              state_n = ST_DRAIN;
            end
          end
        end
      end
      ST_WRITE: begin
        if (s_hs) begin
          if (len_q == 8'd0) begin
            code_n = RSP_ACK;
            if (s_axis_tlast_i) begin
              state_n   = ST_RESP;
              resp_ld   = 1'b1;
              resp_code = RSP_ACK;
            end else begin
              state_n = ST_DRAIN;
            end
          end else if (s_axis_tlast_i) begin
            state_n = ST_RESP;
            resp_ld = 1'b1;
            err_n   = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (s_hs && s_axis_tlast_i) begin
          state_n   = ST_RESP;
          resp_ld   = 1'b1;
          resp_code = code_q;
        end
      end
      ST_READ: if (pop && out_last) state_n = ST_HDR;
      ST_RESP: if (pop)             state_n = ST_HDR;
      default: state_n = ST_HDR;
    endcase
  end

  // control state: FSM, header capture, address and byte counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_HDR;
      hdr_cnt   <= 2'd0;
      cmd_q     <= 8'h00;
      addr_lo_q <= 8'h00;
      addr_q    <= '0;
      len_q     <= 8'h00;
      rd_left   <= 9'd0;
      code_q    <= 8'h00;
      err_q     <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      state    <= state_n;
      code_q   <= code_n;
      err_q    <= err_n;
      if (state == ST_HDR && s_hs) begin
        hdr_cnt <= s_axis_tlast_i ? 2'd0 : hdr_cnt + 2'd1;
        case (hdr_cnt)
          2'd0: cmd_q     <= s_axis_tdata_i;
          2'd1: addr_lo_q <= s_axis_tdata_i;
          2'd2: addr_q    <= ABITS'({s_axis_tdata_i, addr_lo_q});
          default: begin
            len_q   <= s_axis_tdata_i;
            rd_left <= {1'b0, s_axis_tdata_i} + 9'd1;
          end
        endcase
      end
      if (sram_en)  addr_q  <= addr_q + 1'b1;
      if (sram_we)  len_q   <= len_q - 8'd1;
      if (rd_issue) rd_left <= rd_left - 9'd1;
    end
  end

  // output datapath: response byte or read data through skid register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_pend   <= 1'b0;
      rd_last   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= 8'h00;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
    end else if (resp_ld) begin
      out_vld  <= 1'b1;
      out_last <= 1'b1;
      out_data <= resp_code;
    end else begin
      rd_pend <= rd_issue;
      rd_last <= rd_issue && (rd_left == 9'd1);
      if (pop || !out_vld) begin
        if (skid_vld) begin
          out_vld   <= 1'b1;
          out_data  <= skid_data;
          out_last  <= skid_last;
          skid_vld  <= rd_pend;
          skid_data <= rdata;
          skid_last <= rd_last;
        end else if (rd_pend) begin
          out_vld  <= 1'b1;
          out_data <= rdata;
          out_last <= rd_last;
        end else begin
          out_vld  <= 1'b0;
          out_last <= 1'b0;
        end
      end else if (rd_pend) begin
        skid_vld  <= 1'b1;
        skid_data <= rdata;
        skid_last <= rd_last;
      end
    end
  end

endmodule

// File: tb/tb_axis_sram_bridge.sv
// Bench for axis_sram_bridge: directed vector table, randomized
// write/read-back against a packet-level memory model, backpressure and
// mid-read reset sequences.
module tb_axis_sram_bridge;

  typedef logic [8:0] bq_t[$];   // {tlast, byte}

  typedef struct {
    int              n;
    logic [0:11][7:0] b;
    int              ne;
    logic [0:3][7:0] e;
    int              eerr;
  } vec_t;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tready;
  logic       m_tvalid, m_tlast;
  logic       m_tready = 1'b1;
  logic [7:0] m_tdata;
  logic       busy, err;

  int nvec = 0, nbad = 0;
  int cyc = 0;
  int errcnt = 0, hold_viol = 0, last_rise = 0, hdr4_edge = 0;
  logic rnd_rdy = 1'b0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = 8'h00;
  bq_t rxq;
  logic [7:0] mem [0:2047];

  axis_sram_bridge dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tready_o (s_tready),
    .s_axis_tlast_i  (s_tlast),
    .s_axis_tdata_i  (s_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tready_i (m_tready),
    .m_axis_tlast_o  (m_tlast),
    .m_axis_tdata_o  (m_tdata),
    .busy_o          (busy),
    .err_o           (err)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #1;
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // output monitor: collect handshaken bytes, hold-rule and err pulses
  always @(negedge aclk) begin
    if (aresetn && pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl))
      hold_viol++;
    if (m_tvalid && !pv) last_rise = cyc;
    if (aresetn && m_tvalid && m_tready) rxq.push_back({m_tlast, m_tdata});
    if (err === 1'b1) errcnt++;
    pv = m_tvalid && aresetn;
    pr = m_tready;
    pd = m_tdata;
    pl = m_tlast;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bq_t mk_hdr(input logic [7:0] cmd, input logic [15:0] a,
                                 input logic [7:0] len, input logic last4);
    bq_t q;
    q = {};
    q.push_back({1'b0, cmd});
    q.push_back({1'b0, a[7:0]});
    q.push_back({1'b0, a[15:8]});
    q.push_back({last4, len});
    return q;
  endfunction

  // packet-level reference: applies a whole packet to the memory model
  task automatic model_pkt(input bq_t q, output bq_t e, output int eerr);
    logic [7:0] cmd;
    int a, n, k;
    e = {};
    eerr = 0;
    if (q.size() < 4) return;
    for (int i = 0; i < 3; i++) if (q[i][8]) return;
    cmd = q[0][7:0];
    a = {q[2][7:0], q[1][7:0]} % 2048;
    n = int'(q[3][7:0]) + 1;
    if (cmd == 8'h01) begin
      if (q[3][8]) return;
      k = q.size() - 4;
      for (int i = 0; i < k && i < n; i++) mem[(a + i) % 2048] = q[4 + i][7:0];
      if (k < n) begin
        e.push_back({1'b1, 8'hEE});
        eerr = 1;
      end else begin
        e.push_back({1'b1, 8'hA5});
      end
    end else if (cmd == 8'h02) begin
      for (int i = 0; i < n; i++) e.push_back({i == n - 1, mem[(a + i) % 2048]});
    end else begin
      e.push_back({1'b1, 8'hEE});
      eerr = 1;
    end
  endtask

  // starts and ends at posedge+1
  task automatic send_pkt(input bq_t q);
    int guard;
    logic acc;
    foreach (q[i]) begin
      s_tvalid = 1'b1;
      s_tdata  = q[i][7:0];
      s_tlast  = q[i][8];
      guard = 0;
      do begin
        @(negedge aclk);
        acc = s_tready;
        if (acc && i == 3) hdr4_edge = cyc + 1;
        @(posedge aclk);
        #1;
        guard++;
      end while (!acc && guard < 300);
      if (!acc) chk("s_tready_timeout", 32'(acc), 32'd1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic collect(input int n, input int maxc);
    int c;
    c = 0;
    while (rxq.size() < n && c < maxc) begin
      @(posedge aclk);
      #1;
      c++;
    end
    repeat (4) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic apply(input bq_t q, input bq_t exp, input int eerr,
                       input int maxc, input string tag);
    int rb, eb, hb;
    rb = rxq.size();
    eb = errcnt;
    hb = hold_viol;
    send_pkt(q);
    collect(rb + exp.size(), maxc);
    chk({tag, "_count"}, rxq.size() - rb, exp.size());
    for (int i = 0; i < exp.size() && rb + i < rxq.size(); i++)
      chk({tag, "_byte"}, 32'(rxq[rb + i]), 32'(exp[i]));
    chk({tag, "_err_pulses"}, errcnt - eb, eerr);
    chk({tag, "_hold"}, hold_viol - hb, 0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vt[12];
    bq_t q, e, me;
    int mee, a, n, rb, c;
    logic [15:0] a256;

    vt[0]  = '{8, {8'h01,8'h10,8'h00,8'h03,8'h11,8'h22,8'h33,8'h44,32'h0}, 1, {8'hA5,24'h0}, 0};
    vt[1]  = '{4, {8'h02,8'h10,8'h00,8'h03,64'h0}, 4, {8'h11,8'h22,8'h33,8'h44}, 0};
    vt[2]  = '{8, {8'h01,8'hFE,8'h07,8'h03,8'hC1,8'hC2,8'hC3,8'hC4,32'h0}, 1, {8'hA5,24'h0}, 0};
    vt[3]  = '{4, {8'h02,8'hFE,8'h07,8'h03,64'h0}, 4, {8'hC1,8'hC2,8'hC3,8'hC4}, 0};
    vt[4]  = '{7, {8'h7F,8'h00,8'h00,8'h00,8'h01,8'h02,8'h03,40'h0}, 1, {8'hEE,24'h0}, 1};
    vt[5]  = '{6, {8'h01,8'h00,8'h01,8'h03,8'hAA,8'hBB,48'h0}, 1, {8'hEE,24'h0}, 1};
    vt[6]  = '{4, {8'h02,8'h00,8'h01,8'h01,64'h0}, 2, {8'hAA,8'hBB,16'h0}, 0};
    vt[7]  = '{7, {8'h01,8'h20,8'h00,8'h01,8'h55,8'h66,8'h77,40'h0}, 1, {8'hA5,24'h0}, 0};
    vt[8]  = '{4, {8'h02,8'h20,8'h00,8'h01,64'h0}, 2, {8'h55,8'h66,16'h0}, 0};
    vt[9]  = '{2, {8'h02,8'h10,80'h0}, 0, 32'h0, 0};
    vt[10] = '{4, {8'h33,8'h00,8'h00,8'h00,64'h0}, 1, {8'hEE,24'h0}, 1};
    vt[11] = '{4, {8'h02,8'h12,8'h00,8'h00,64'h0}, 1, {8'h33,24'h0}, 0};

    // reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tlast",  32'(m_tlast), 0);
    chk("rst_m_tdata",  32'(m_tdata), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_err",      32'(err), 0);
    aresetn = 1'b1;
    #1;
    chk("rst_release_tready_low", 32'(s_tready), 0);
    @(posedge aclk);
    #1;
    chk("rst_release_tready_high", 32'(s_tready), 1);

    // directed table
    for (int i = 0; i < 12; i++) begin
      q = {};
      e = {};
      for (int j = 0; j < vt[i].n; j++) q.push_back({j == vt[i].n - 1, vt[i].b[j]});
      for (int j = 0; j < vt[i].ne; j++) e.push_back({j == vt[i].ne - 1, vt[i].e[j]});
      model_pkt(q, me, mee);
      apply(q, e, vt[i].eerr, 100, $sformatf("vec%0d", i));
      if (i == 1) chk("read_first_valid_latency", last_rise - hdr4_edge, 2);
    end

    // randomized write / read-back with random consumer backpressure
    rnd_rdy = 1'b1;
    for (int t = 0; t < 6; t++) begin
      a = $urandom_range(0, 2047);
      n = $urandom_range(1, 24);
      q = mk_hdr(8'h01, 16'(a), 8'(n - 1), 1'b0);
      for (int i = 0; i < n; i++) q.push_back({i == n - 1, 8'($urandom)});
      model_pkt(q, e, mee);
      apply(q, e, mee, 200, "rnd_wr");
      q = mk_hdr(8'h02, 16'(a), 8'(n - 1), 1'b1);
      model_pkt(q, e, mee);
      apply(q, e, mee, 400, "rnd_rd");
    end

    // full 256-byte write then read under random backpressure
    a256 = 16'($urandom_range(0, 2047));
    q = mk_hdr(8'h01, a256, 8'hFF, 1'b0);
    for (int i = 0; i < 256; i++) q.push_back({i == 255, 8'($urandom)});
    model_pkt(q, e, mee);
    apply(q, e, mee, 200, "wr256");
    q = mk_hdr(8'h02, a256, 8'hFF, 1'b1);
    model_pkt(q, e, mee);
    apply(q, e, mee, 4000, "rd256");

    // reset in the middle of a read stream
    q = mk_hdr(8'h02, a256, 8'hFF, 1'b1);
    rb = rxq.size();
    send_pkt(q);
    c = 0;
    while (rxq.size() < rb + 10 && c < 500) begin
      @(posedge aclk);
      #1;
      c++;
    end
    chk("midread_started", 32'(rxq.size() - rb >= 10), 1);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 0);
    chk("midrst_m_tlast",  32'(m_tlast), 0);
    chk("midrst_m_tdata",  32'(m_tdata), 0);
    chk("midrst_s_tready", 32'(s_tready), 0);
    chk("midrst_busy",     32'(busy), 0);
    chk("midrst_err",      32'(err), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    rnd_rdy = 1'b0;
    q = mk_hdr(8'h02, a256, 8'h07, 1'b1);
    model_pkt(q, e, mee);
    apply(q, e, mee, 100, "post_rst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/axis_sram_bridge.md
AXIS_SRAM_BRIDGE -- requirements
Module: axis_sram_bridge

Interface
REQ-001 The block SHALL have parameter ABITS, default 11, which sets the SRAM byte-address width (2^ABITS bytes).
REQ-002 The block SHALL have parameter RSP_ACK, default 8'hA5, the write-acknowledge byte.
REQ-003 The block SHALL have parameter RSP_ERR, default 8'hEE, the error byte.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; all other ports SHALL be as listed in REQ-005 to REQ-015.
REQ-005 Port aclk, input, 1 bit: the single clock.
REQ-006 Port aresetn, input, 1 bit: asynchronous active-low reset.
REQ-007 Port s_axis_tvalid_i, input, 1 bit: command/data byte valid (from USB OUT).
REQ-008 Port s_axis_tready_o, output, 1 bit: byte accepted.
REQ-009 Port s_axis_tlast_i, input, 1 bit: last byte of the packet.
REQ-010 Port s_axis_tdata_i, input, 8 bits: the byte.
REQ-011 Port m_axis_tvalid_o, output, 1 bit: response byte valid (to USB IN).
REQ-012 Port m_axis_tready_i, input, 1 bit: response byte taken.
REQ-013 Port m_axis_tlast_o, output, 1 bit: last response byte.
REQ-014 Port m_axis_tdata_o, output, 8 bits: response byte.
REQ-015 Ports busy_o (1 bit, high whenever state is not HDR) and err_o (1 bit, one-cycle pulse per rejected packet), both outputs.

Function
REQ-016 Header format SHALL be 4 bytes: CMD, ADDR_LO, ADDR_HI, LEN; address = {ADDR_HI,ADDR_LO}[ABITS-1:0]; byte count N = LEN+1 (1..256).
REQ-017 CMD 8'h01 (WRITE): the next N bytes SHALL be written to addr, addr+1, ... with the address wrapping modulo 2^ABITS.
REQ-018 CMD 8'h02 (READ): the block SHALL emit N bytes read from addr upward (wrapping), with m_axis_tlast_o high only on byte N.
REQ-019 States SHALL be HDR, WRITE, READ, RESP, DRAIN; a byte transfers only when valid and ready are both high.
REQ-020 HDR: s_axis_tready_o=1; a 2-bit counter SHALL index header bytes; tlast on any header byte SHALL discard the header and stay in HDR with no response.
REQ-021 After the 4th header byte: WRITE leads to WRITE; READ leads to READ; any other CMD leads to RESP(RSP_ERR) if that byte has tlast, else DRAIN, and err_o SHALL pulse.
REQ-022 WRITE: s_axis_tready_o=1 and each accepted byte SHALL be written to SRAM the same cycle; on byte N with tlast the block SHALL go to RESP(RSP_ACK).
REQ-023 WRITE boundary: byte N without tlast SHALL lead to DRAIN, then RESP(RSP_ACK); tlast before byte N SHALL lead to RESP(RSP_ERR) with err_o pulsed, bytes already written staying written.
REQ-024 DRAIN: s_axis_tready_o=1, bytes discarded until tlast, then RESP with the pending code.
REQ-025 READ: s_axis_tready_o=0; SRAM read latency is 1 cycle; m_axis_tvalid_o SHALL first rise 2 cycles after the 4th header handshake.
REQ-026 READ throughput: sustained 1 byte/cycle while m_axis_tready_i=1; backpressure SHALL not lose or duplicate bytes (1-entry skid register).
REQ-027 READ SHALL return to HDR on the cycle after the tlast byte handshakes; read packets SHALL carry no trailing ACK.
REQ-028 RESP: exactly one byte SHALL be emitted with m_axis_tlast_o=1, s_axis_tready_o=0; after its handshake the block SHALL return to HDR.
REQ-029 m_axis_tvalid_o, once high, SHALL hold with stable tdata/tlast until handshake (AXI-Stream rule).
REQ-030 Input tlast on the final READ header byte SHALL be legal; extra input bytes after a READ header SHALL be treated as a new header.

Reset
REQ-031 On aresetn low, asynchronously: state=HDR, counters=0, s_axis_tready_o=0, m_axis_tvalid_o=0, m_axis_tlast_o=0, m_axis_tdata_o=8'h00, busy_o=0, err_o=0.
REQ-032 s_axis_tready_o SHALL rise the first cycle after aresetn deasserts.
REQ-033 SRAM contents SHALL NOT be reset; reset mid-transfer abandons the packet, with writes already done retained.

Structure
REQ-034 Package axis_sram_pkg SHALL hold CMD_WRITE/CMD_READ opcodes, default response codes and the state encoding.
REQ-035 Storage SHALL be a sub-module sram_byte: single-port, synchronous write, 1-cycle registered read, inferable as block RAM.

Verification
REQ-036 Write {01,10,00,03,11,22,33,44(tlast)} -> one byte A5 with tlast; SRAM[0x010..0x013]=11,22,33,44.
REQ-037 Read {02,10,00,03(tlast)} with m_axis_tready_i=1 -> 11,22,33,44, tlast on 44, first valid 2 cycles after the header.
REQ-038 Wrap test with ABITS=11: write 4 bytes at 0x7FE, then read 4 bytes at 0x7FE -> data returned from 0x7FE,0x7FF,0x000,0x001.
REQ-039 Random m_axis_tready_i on a 256-byte read (LEN=FF) -> all 256 bytes in order, no loss or duplication.
REQ-040 CMD 7F with 3 trailing bytes -> err_o pulses once, bytes drained, EE emitted with tlast; a short write (tlast at byte 2 of 4) -> EE.
REQ-041 aresetn pulsed mid-read -> outputs take their REQ-031 values immediately; a subsequent read returns the prior SRAM data.
